// File: rtl/uart_frame_parser.sv
// uart_frame_parser: locates HDR0 HDR1 LEN PAYLOAD CHK frames in the UART byte stream,
// verifies the additive checksum and replays good payloads on a valid/ready port.
module uart_frame_parser #(
    parameter int         MAX_LEN     = 16,
    parameter logic [7:0] HDR0        = 8'h55,
    parameter logic [7:0] HDR1        = 8'hAA,
    parameter int         TIMEOUT_CYC = 52_080
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pld_data,
    output logic       pld_valid,
    input  logic       pld_ready,
    output logic       pld_last,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int AW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_CHK = 2'd0;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_OVR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        H1,
        LEN,
        DATA,
        CHK,
        SEND
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    pbuf [0:MAX_LEN-1];
    logic [CW-1:0] len;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rd_ptr;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;
    logic          ovr_pend;

    logic          in_frame;
    logic          tmo_hit;
    logic          len_ok;
    logic          last_beat;
    logic          xfer;
    logic          done_set;
    logic          ovr;
    logic          ovr_now;
    logic          err_set;
    logic [1:0]    err_set_code;

    assign in_frame  = (state == H1) || (state == LEN) || (state == DATA) || (state == CHK);
    assign tmo_hit   = in_frame && !rx_valid && (tmo == TMO_LAST);
    assign len_ok    = (rx_data != 8'd0) && (rx_data <= MAX_LEN_B);
    assign last_beat = (rd_ptr == len - CNT_ONE);
    assign xfer      = (state == SEND) && pld_ready;
    assign done_set  = xfer && last_beat;
    assign ovr       = (state == SEND) && rx_valid;
    // An overrun on the final transfer is reported one cycle late so it never overlaps frame_done.
    assign ovr_now   = ovr && !done_set;

    always_comb begin
        state_nxt    = state;
        err_set      = 1'b0;
        err_set_code = ERR_CHK;
        pld_valid    = 1'b0;
        pld_data     = 8'h00;
        pld_last     = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (rx_valid && (rx_data == HDR0)) state_nxt = H1;
            end
            H1: begin
                if (rx_valid) begin
                    if (rx_data == HDR1)      state_nxt = LEN;
                    else if (rx_data != HDR0) state_nxt = IDLE;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    if (len_ok) begin
                        state_nxt = DATA;
                    end else begin
                        state_nxt    = IDLE;
                        err_set      = 1'b1;
                        err_set_code = ERR_LEN;
                    end
                end
            end
            DATA: begin
                if (rx_valid && (cnt == len - CNT_ONE)) state_nxt = CHK;
            end
            CHK: begin
                if (rx_valid) begin
                    if (rx_data == sum) begin
                        state_nxt = SEND;
                    end else begin
                        state_nxt    = IDLE;
                        err_set      = 1'b1;
                        err_set_code = ERR_CHK;
                    end
                end
            end
            SEND: begin
                pld_valid = 1'b1;
                pld_data  = pbuf[rd_ptr[AW-1:0]];
                pld_last  = last_beat;
                if (done_set) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt    = IDLE;
            err_set      = 1'b1;
            err_set_code = ERR_TMO;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            len    <= '0;
            cnt    <= '0;
            rd_ptr <= '0;
            sum    <= 8'h00;
            tmo    <= '0;
        end else begin
            if (rx_valid || !in_frame || tmo_hit) tmo <= '0;
            else                                  tmo <= tmo + TMO_ONE;
            case (state)
                LEN: begin
                    if (rx_valid && len_ok) begin
                        len <= rx_data[CW-1:0];
                        sum <= rx_data;
                        cnt <= '0;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        sum <= sum + rx_data;
                        cnt <= cnt + CNT_ONE;
                    end
                end
                CHK:  rd_ptr <= '0;
                SEND: if (xfer) rd_ptr <= rd_ptr + CNT_ONE;
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; it is only read after being written in DATA.
    always_ff @(posedge sys_clk) begin
        if ((state == DATA) && rx_valid) pbuf[cnt[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
            ovr_pend   <= 1'b0;
        end else begin
            frame_done <= done_set;
            ovr_pend   <= ovr && done_set;
            frame_err  <= err_set || ovr_pend || ovr_now;
            if (err_set)                  err_code <= err_set_code;
            else if (ovr_pend || ovr_now) err_code <= ERR_OVR;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_frame_parser;
    localparam int         MAX_LEN = 16;
    localparam int         TMO     = 40;
    localparam logic [7:0] HDR0    = 8'h55;
    localparam logic [7:0] HDR1    = 8'hAA;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_ready = 1'b1;
    logic       pld_last;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;

    logic [8:0] exp_beats[$];
    logic [1:0] exp_errs[$];

    uart_frame_parser #(
        .MAX_LEN(MAX_LEN), .HDR0(HDR0), .HDR1(HDR1), .TIMEOUT_CYC(TMO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
        .pld_last(pld_last), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Sink readiness: 0 always ready, 1 stalled, 2 random, 3 toggling
    initial begin
        forever begin
            @(posedge sys_clk); #1;
            case (rdy_mode)
                0:       pld_ready = 1'b1;
                1:       pld_ready = 1'b0;
                2:       pld_ready = ($urandom_range(0, 3) != 0);
                default: pld_ready = ~pld_ready;
            endcase
        end
    end

    logic       prev_stall = 1'b0;
    logic       last_prev  = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;
    logic [8:0] mon_beat;
    logic [1:0] mon_err;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            prev_stall = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (last_prev || frame_done)
                check("frame_done_timing", 32'(frame_done), 32'(last_prev));
            if (frame_err) begin
                if (exp_errs.size() == 0) begin
                    check("frame_err_unexpected", 32'(frame_err), 32'd0);
                end else begin
                    mon_err = exp_errs.pop_front();
                    check("err_code", 32'(err_code), 32'(mon_err));
                end
            end
            check("err_done_exclusive", 32'(frame_err & frame_done), 32'd0);
            if (prev_stall) begin
                check("bp_valid_held", 32'(pld_valid), 32'd1);
                check("bp_data_held", 32'(pld_data), 32'(prev_data));
                check("bp_last_held", 32'(pld_last), 32'(prev_last));
            end
            if (!pld_valid)
                check("idle_outputs_zero", 32'({pld_last, pld_data}), 32'd0);
            if (pld_valid && pld_ready) begin
                if (exp_beats.size() == 0) begin
                    check("beat_unexpected", 32'(pld_valid), 32'd0);
                end else begin
                    mon_beat = exp_beats.pop_front();
                    check("beat_data", 32'(pld_data), 32'(mon_beat[7:0]));
                    check("beat_last", 32'(pld_last), 32'(mon_beat[8]));
                end
            end
            last_prev  = pld_valid && pld_ready && pld_last;
            prev_stall = pld_valid && !pld_ready;
            prev_data  = pld_data;
            prev_last  = pld_last;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge sys_clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || exp_beats.size() != 0) && n < 3000) begin
            @(posedge sys_clk); #1;
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        repeat (2) begin
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic send_case1();
        exp_beats.push_back({1'b0, 8'h11});
        exp_beats.push_back({1'b0, 8'h22});
        exp_beats.push_back({1'b1, 8'h33});
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        send_byte(8'h69, 0);
    endtask

    // Reference model: a frame is judged from its LEN and payload with plain arithmetic.
    task automatic rand_frame();
        int         len;
        int         s;
        bit         good;
        logic [7:0] pl[$];
        logic [7:0] chk;
        if ($urandom_range(0, 7) == 0)
            len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 40));
        else
            len = int'($urandom_range(1, MAX_LEN));
        send_byte(HDR0, $urandom_range(0, 3));
        send_byte(HDR1, $urandom_range(0, 3));
        if (len == 0 || len > MAX_LEN) begin
            exp_errs.push_back(2'd1);
            send_byte(8'(len), 0);
            return;
        end
        s = len;
        for (int i = 0; i < len; i++) begin
            pl.push_back(8'($urandom));
            s += int'(pl[i]);
        end
        good = ($urandom_range(0, 3) != 0);
        chk  = good ? 8'(s % 256) : 8'((s + int'($urandom_range(1, 255))) % 256);
        if (good) begin
            for (int i = 0; i < len; i++) exp_beats.push_back({(i == len - 1), pl[i]});
        end else begin
            exp_errs.push_back(2'd0);
        end
        send_byte(8'(len), $urandom_range(0, 3));
        for (int i = 0; i < len; i++) send_byte(pl[i], $urandom_range(0, 3));
        send_byte(chk, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        bit         got;
        logic [7:0] noise;

        rdy_mode = 0;
        sys_rst  = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pld_valid", 32'(pld_valid), 32'd0);
        check("rst_pld_data", 32'(pld_data), 32'd0);
        check("rst_pld_last", 32'(pld_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        // Case 1: good three-byte frame with the sink always ready
        send_case1();
        check("t1_latency_valid", 32'(pld_valid), 32'd1);
        check("t1_first_data", 32'(pld_data), 32'h11);
        wait_idle("t1_idle");

        // Case 2: checksum mismatch
        exp_errs.push_back(2'd0);
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h02, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        check("t2_err_pulse", 32'(frame_err), 32'd1);
        check("t2_no_valid", 32'(pld_valid), 32'd0);
        wait_idle("t2_idle");

        // Case 3: LEN of zero and LEN above MAX_LEN, then a good frame
        exp_errs.push_back(2'd1);
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h00, 0);
        check("t3_len0_err", 32'(frame_err), 32'd1);
        exp_errs.push_back(2'd1);
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h11, 0);
        check("t3_len17_err", 32'(frame_err), 32'd1);
        send_case1();
        wait_idle("t3_idle");

        // Case 4: stalled sink, overrun byte during replay, then toggling ready
        rdy_mode = 1;
        repeat (2) begin
            @(posedge sys_clk); #1;
        end
        send_case1();
        repeat (10) begin
            @(posedge sys_clk); #1;
        end
        check("t4_stall_valid", 32'(pld_valid), 32'd1);
        check("t4_stall_data", 32'(pld_data), 32'h11);
        exp_errs.push_back(2'd3);
        send_byte(8'h5A, 0);
        check("t4_ovr_err", 32'(frame_err), 32'd1);
        check("t4_still_busy", 32'(busy), 32'd1);
        rdy_mode = 3;
        wait_idle("t4_idle");
        rdy_mode = 0;

        // Case 5: inter-byte timeout, then resync on a doubled header
        exp_errs.push_back(2'd2);
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h04, 0); send_byte(8'h01, 0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 3 * TMO) begin
            @(posedge sys_clk); #1;
            n++;
            if (frame_err) got = 1'b1;
        end
        check("t5_timeout_cycles", 32'(n), 32'(TMO));
        check("t5_timeout_idle", 32'(busy), 32'd0);
        exp_beats.push_back({1'b1, 8'h07});
        send_byte(8'h55, 0); send_byte(8'h55, 0); send_byte(8'hAA, 0);
        send_byte(8'h01, 0); send_byte(8'h07, 0); send_byte(8'h08, 0);
        check("t5_single_last", 32'(pld_last), 32'd1);
        wait_idle("t5_idle");

        // Case 6: reset in the middle of a payload
        send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
        check("t6_busy_before", 32'(busy), 32'd1);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_pld_valid", 32'(pld_valid), 32'd0);
        check("t6_pld_data", 32'(pld_data), 32'd0);
        check("t6_frame_err", 32'(frame_err), 32'd0);
        check("t6_frame_done", 32'(frame_done), 32'd0);
        check("t6_err_code", 32'(err_code), 32'd0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        send_case1();
        wait_idle("t6_idle");

        // Randomized frames with random backpressure and idle-line noise
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            rand_frame();
            wait_idle("rand_idle");
            if ($urandom_range(0, 2) == 0) begin
                noise = 8'($urandom);
                if (noise == HDR0) noise = 8'h00;
                send_byte(noise, 1);
            end
        end
        rdy_mode = 0;
        wait_idle("final_idle");
        repeat (5) begin
            @(posedge sys_clk); #1;
        end
        check("beats_drained", 32'(exp_beats.size()), 32'd0);
        check("errs_drained", 32'(exp_errs.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
